// File: rtl/datapath_unit_if.sv
// Operand/opcode/select interface between the control unit (master) and datapath_unit (slave).
interface datapath_unit_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] offset;
  logic [3:0]            opcode;
  logic                  sel1;
  logic                  sel3;
  logic                  w_r;
  logic [DATA_WIDTH-1:0] result2;
  logic                  zero;
  logic                  carry;
  logic                  addr_err;

  modport master (
    output operand1, operand2, offset, opcode, sel1, sel3, w_r,
    input  result2, zero, carry, addr_err
  );

  modport slave (
    input  operand1, operand2, offset, opcode, sel1, sel3, w_r,
    output result2, zero, carry, addr_err
  );
endinterface

// File: rtl/datapath_unit.sv
// Execution datapath: operand select, registered ALU stage, 32x8 data memory with async read,
// and the combinational write-back mux returned to the control unit.
module datapath_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5
) (
  input  logic             clk,
  input  logic             rst,
  datapath_unit_if.slave   bus
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpXor  = 4'h4,
    OpNot  = 4'h5,
    OpShl  = 4'h6,
    OpShr  = 4'h7,
    OpPassA = 4'h8,
    OpPassB = 4'h9,
    OpNop  = 4'hF
  } alu_op_e;

  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH:0]   sum;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic                  addr_err;
  logic [DATA_WIDTH-1:0] rd_data;

  assign op_a = bus.operand1;
  assign op_b = bus.sel3 ? bus.offset : bus.operand2;
  assign sum  = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    alu_d   = alu_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (bus.opcode != OpNop) begin
      carry_d = 1'b0;
      unique case (bus.opcode)
        OpAdd: begin
          alu_d   = sum[DATA_WIDTH-1:0];
          carry_d = sum[DATA_WIDTH];
        end
        OpSub: begin
          alu_d   = op_a - op_b;
          carry_d = (op_a < op_b);
        end
        OpAnd:   alu_d = op_a & op_b;
        OpOr:    alu_d = op_a | op_b;
        OpXor:   alu_d = op_a ^ op_b;
        OpNot:   alu_d = ~op_a;
        OpShl:   alu_d = op_a << op_b[2:0];
        OpShr:   alu_d = op_a >> op_b[2:0];
        OpPassA: alu_d = op_a;
        OpPassB: alu_d = op_b;
        default: alu_d = '0;
      endcase
      zero_d = (alu_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      wdata_q <= bus.operand2;
      we_q    <= bus.w_r;
    end
  end

  // Upper ALU bits must be clear for a valid address; out-of-range never wraps.
  assign mem_addr = alu_q[ADDR_BITS-1:0];
  assign addr_err = |alu_q[DATA_WIDTH-1:ADDR_BITS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_q && !addr_err) begin
      mem_q[mem_addr] <= wdata_q;
    end
  end

  assign rd_data = addr_err ? '0 : mem_q[mem_addr];

  assign bus.result2  = bus.sel1 ? alu_q : rd_data;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.addr_err = addr_err;

endmodule

// File: tb/tb_datapath_unit.sv
// Randomised and directed bench for datapath_unit against a transaction-level reference model.
module tb_datapath_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  datapath_unit_if #(.DATA_WIDTH(8)) bus ();

  datapath_unit #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: plain integers and an array, updated once per accepted clock edge.
  int mem_m [32];
  int alu_m, wdata_m;
  bit zero_m, carry_m, we_m;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 0;
    alu_m = 0; wdata_m = 0; zero_m = 0; carry_m = 0; we_m = 0;
  endtask

  task automatic model_edge();
    int a, b, r;
    bit c;
    if (!rst) return;
    if (we_m && alu_m < 32) mem_m[alu_m] = wdata_m;
    a = int'(bus.operand1);
    b = bus.sel3 ? int'(bus.offset) : int'(bus.operand2);
    c = 0;
    r = 0;
    case (int'(bus.opcode))
      0: begin r = (a + b) % 256; c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; c = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = (a * (1 << (b % 8))) % 256;
      7: r = a / (1 << (b % 8));
      8: r = a;
      9: r = b;
      default: r = 0;
    endcase
    if (bus.opcode != 4'hF) begin
      alu_m = r; carry_m = c; zero_m = (r == 0);
    end
    wdata_m = int'(bus.operand2);
    we_m = bus.w_r;
  endtask

  function automatic int exp_result2();
    if (bus.sel1) return alu_m;
    return (alu_m < 32) ? mem_m[alu_m] : 0;
  endfunction

  task automatic compare_all();
    check("result2", bus.result2, exp_result2());
    check("zero", bus.zero, zero_m);
    check("carry", bus.carry, carry_m);
    check("addr_err", bus.addr_err, alu_m >= 32);
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] off, input logic s1, input logic s3, input logic wr);
    bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.offset = off;
    bus.sel1 = s1; bus.sel3 = s3; bus.w_r = wr;
  endtask

  task automatic step(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] off, input logic s1, input logic s3, input logic wr);
    drive(op, a, b, off, s1, s3, wr);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Load every word via pass-B addressing and compare with the model and an expected constant.
  task automatic read_all(input bit expect_zero);
    for (int i = 0; i < 32; i++) begin
      step(4'h9, 8'd0, 8'(i), 8'd0, 1'b0, 1'b0, 1'b0);
      if (expect_zero) check("mem_zero", bus.result2, 0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_result2", bus.result2, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(4'hF, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    model_reset();
    #12;
    compare_all();
    rst = 1'b1;

    // Dirty some state, then reset mid-run and confirm every word reads 0.
    for (int i = 0; i < 8; i++) step(4'h8, 8'(i * 3), 8'(8'h11 * i + 1), 8'd0, 1'b1, 1'b0, 1'b1);
    apply_reset();
    check("rst_zero", bus.zero, 0);
    check("rst_carry", bus.carry, 0);
    read_all(1'b1);

    // ALU directed cases
    step(4'h0, 8'd200, 8'd100, 8'd0, 1'b1, 1'b0, 1'b0);
    check("add_res", bus.result2, 44);
    check("add_carry", bus.carry, 1);
    check("add_zero", bus.zero, 0);
    step(4'h1, 8'd5, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0);
    check("sub_eq_res", bus.result2, 0);
    check("sub_eq_zero", bus.zero, 1);
    check("sub_eq_carry", bus.carry, 0);
    step(4'h1, 8'd3, 8'd5, 8'd0, 1'b1, 1'b0, 1'b0);
    check("sub_lt_res", bus.result2, 8'hFE);
    check("sub_lt_carry", bus.carry, 1);

    // Store A5 to address 4+6 for two cycles, then load it back.
    step(4'h0, 8'd4, 8'h00, 8'd6, 1'b1, 1'b1, 1'b1);
    step(4'h0, 8'd4, 8'hA5, 8'd6, 1'b1, 1'b1, 1'b1);
    step(4'h0, 8'd4, 8'hA5, 8'd6, 1'b0, 1'b1, 1'b0);
    check("load_a5", bus.result2, 8'hA5);
    step(4'h0, 8'd4, 8'h00, 8'd6, 1'b0, 1'b1, 1'b0);
    check("load_a5_again", bus.result2, 8'hA5);

    // Out-of-range store at 35: suppressed, load returns 0.
    step(4'h0, 8'd30, 8'h5A, 8'd5, 1'b1, 1'b1, 1'b1);
    check("oor_err", bus.addr_err, 1);
    step(4'h0, 8'd30, 8'h5A, 8'd5, 1'b0, 1'b1, 1'b1);
    check("oor_load", bus.result2, 0);
    step(4'h0, 8'd30, 8'h5A, 8'd5, 1'b0, 1'b1, 1'b0);
    read_all(1'b0);
    step(4'h8, 8'd10, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("oor_keep10", bus.result2, 8'hA5);
    step(4'h8, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("oor_no_wrap", bus.result2, 0);

    // NOP holds ALU result and flags.
    step(4'h0, 8'd2, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0);
    check("nop_pre", bus.result2, 5);
    step(4'hF, 8'd99, 8'd77, 8'd13, 1'b1, 1'b1, 1'b0);
    check("nop_hold", bus.result2, 5);
    check("nop_zero", bus.zero, 0);
    check("nop_carry", bus.carry, 0);

    // Reset lands between the store being registered and its write edge.
    step(4'h8, 8'd12, 8'h77, 8'd0, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    model_reset();
    drive(4'h8, 8'd12, 8'h77, 8'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    step(4'h8, 8'd12, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_store", bus.result2, 0);
    step(4'h8, 8'd12, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_store2", bus.result2, 0);

    // Random traffic, biased toward in-range addresses and boundary values.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] op;
      logic [7:0] a, b, off;
      op  = 4'($urandom_range(0, 15));
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 36));
      b   = 8'($urandom);
      off = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      step(op, a, b, off, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    read_all(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
